// File: rtl/wt_cache_pkg.sv
// Shared types for the write-through cache SHiP/RRIP insertion predictor.
package wt_cache_pkg;

    typedef logic [1:0] rrpv_t;

    localparam rrpv_t RRPV_NEAR    = 2'd0;
    localparam rrpv_t RRPV_LONG    = 2'd2;
    localparam rrpv_t RRPV_DISTANT = 2'd3;

    typedef enum logic [0:0] {
        SHCT_CLEAR = 1'b0,
        SHCT_READY = 1'b1
    } shct_state_e;

endpackage

// File: rtl/wt_dcache_shct_sat_upd.sv
// Saturating increment/decrement of one SHCT counter (purely combinational).
module wt_dcache_shct_sat_upd #(
    parameter int unsigned CntWidth = 2
) (
    input  logic [CntWidth-1:0] cnt_i,
    input  logic                inc_i,  // 1: increment, 0: decrement
    output logic [CntWidth-1:0] cnt_o
);

    localparam logic [CntWidth-1:0] CntMax = {CntWidth{1'b1}};

    // Step the counter one way, holding at the rails
    always_comb begin
        cnt_o = cnt_i;
        if (inc_i) begin
            if (cnt_i != CntMax) cnt_o = cnt_i + CntWidth'(1);
        end else begin
            if (cnt_i != '0) cnt_o = cnt_i - CntWidth'(1);
        end
    end

endmodule

// File: rtl/wt_dcache_shct_predictor.sv
// Signature-history counter table predicting the RRIP insertion RRPV of dcache refills.
// The table is cleared by a one-entry-per-cycle walk after reset or flush.
// Optional lookup statistics are built when WT_DCACHE_SHCT_STATS_EN is defined.
module wt_dcache_shct_predictor
    import wt_cache_pkg::*;
#(
    parameter int unsigned SigWidth = 14,
    parameter int unsigned CntWidth = 2,
    parameter int unsigned InitCnt  = 2**CntWidth - 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    output logic                busy_o,
    input  logic                lookup_req_i,
    input  logic [SigWidth-1:0] lookup_sig_i,
    output logic                lookup_valid_o,
    output logic [1:0]          lookup_rrpv_o,
    input  logic                hit_valid_i,
    input  logic [SigWidth-1:0] hit_sig_i,
    input  logic                evict_valid_i,
    input  logic [SigWidth-1:0] evict_sig_i,
    input  logic                evict_reused_i,
    output logic [31:0]         stat_lookup_o,
    output logic [31:0]         stat_distant_o
);

    localparam int unsigned         Depth   = 2**SigWidth;
    localparam logic [CntWidth-1:0] CntMax  = {CntWidth{1'b1}};
    localparam logic [CntWidth-1:0] InitVal = CntWidth'(InitCnt);

    logic [CntWidth-1:0] table_q [Depth];

    shct_state_e         state_q, state_d;
    logic [SigWidth-1:0] clr_ptr_q, clr_ptr_d;
    logic                ready;

    logic                hit_we, evict_we, same_idx, cancel;
    logic [CntWidth-1:0] hit_cnt_new, evict_cnt_new;

    logic                lk_valid_q;
    logic                lk_clr_q;
    logic [CntWidth-1:0] lk_cnt_q;
    rrpv_t               lk_rrpv;

    assign ready  = (state_q == SHCT_READY);
    assign busy_o = ~ready;

    // Clear-walk sequencing; flush always restarts the walk from index 0
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        if (state_q == SHCT_CLEAR) begin
            clr_ptr_d = clr_ptr_q + SigWidth'(1);
            if (&clr_ptr_q) state_d = SHCT_READY;
        end
        if (flush_i) begin
            state_d   = SHCT_CLEAR;
            clr_ptr_d = '0;
        end
    end

    // FSM and walk pointer state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= SHCT_CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    // Training is ignored during the walk; a hit and a qualifying evict to the same
    // entry cancel out, so neither port writes
    assign hit_we   = ready & hit_valid_i;
    assign evict_we = ready & evict_valid_i & ~evict_reused_i;
    assign same_idx = (hit_sig_i == evict_sig_i);
    assign cancel   = hit_we & evict_we & same_idx;

    wt_dcache_shct_sat_upd #(
        .CntWidth (CntWidth)
    ) u_hit_upd (
        .cnt_i (table_q[hit_sig_i]),
        .inc_i (1'b1),
        .cnt_o (hit_cnt_new)
    );

    wt_dcache_shct_sat_upd #(
        .CntWidth (CntWidth)
    ) u_evict_upd (
        .cnt_i (table_q[evict_sig_i]),
        .inc_i (1'b0),
        .cnt_o (evict_cnt_new)
    );

    // Counter array writes: clear walk, or the two training ports (no reset on storage)
    always_ff @(posedge clk_i) begin
        if (!ready) begin
            table_q[clr_ptr_q] <= InitVal;
        end else begin
            if (hit_we && !cancel)   table_q[hit_sig_i]   <= hit_cnt_new;
            if (evict_we && !cancel) table_q[evict_sig_i] <= evict_cnt_new;
        end
    end

    // Lookup pipeline: capture the pre-update counter and whether we were clearing
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lk_valid_q <= 1'b0;
            lk_clr_q   <= 1'b0;
            lk_cnt_q   <= CntMax;
        end else begin
            lk_valid_q <= lookup_req_i;
            if (lookup_req_i) begin
                lk_clr_q <= ~ready;
                lk_cnt_q <= table_q[lookup_sig_i];
            end
        end
    end

    // Map the registered counter to an insertion RRPV
    always_comb begin
        if (lk_clr_q)                lk_rrpv = RRPV_LONG;
        else if (lk_cnt_q == CntMax) lk_rrpv = RRPV_NEAR;
        else if (lk_cnt_q == '0)     lk_rrpv = RRPV_DISTANT;
        else                         lk_rrpv = RRPV_LONG;
    end

    assign lookup_valid_o = lk_valid_q;
    assign lookup_rrpv_o  = lk_rrpv;

`ifdef WT_DCACHE_SHCT_STATS_EN
    logic [31:0] stat_lookup_q, stat_lookup_d;
    logic [31:0] stat_distant_q, stat_distant_d;

    // Saturating counters stepped on each answered lookup; flush wins over counting
    always_comb begin
        stat_lookup_d  = stat_lookup_q;
        stat_distant_d = stat_distant_q;
        if (flush_i) begin
            stat_lookup_d  = '0;
            stat_distant_d = '0;
        end else if (lk_valid_q) begin
            if (stat_lookup_q != '1) stat_lookup_d = stat_lookup_q + 32'd1;
            if (lk_rrpv == RRPV_DISTANT && stat_distant_q != '1) begin
                stat_distant_d = stat_distant_q + 32'd1;
            end
        end
    end

    // Statistics state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_lookup_q  <= '0;
            stat_distant_q <= '0;
        end else begin
            stat_lookup_q  <= stat_lookup_d;
            stat_distant_q <= stat_distant_d;
        end
    end

    assign stat_lookup_o  = stat_lookup_q;
    assign stat_distant_o = stat_distant_q;
`else
    assign stat_lookup_o  = '0;
    assign stat_distant_o = '0;
`endif

endmodule

// File: tb/tb_wt_dcache_shct_predictor.sv
// Scoreboard bench for wt_dcache_shct_predictor (SigWidth=4, CntWidth=2).
// Stat checks are compiled in when WT_DCACHE_SHCT_STATS_EN is defined.
module tb_wt_dcache_shct_predictor;

    localparam int SigW   = 4;
    localparam int CntW   = 2;
    localparam int Depth  = 16;
    localparam int CntMax = 3;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            flush_i = 1'b0;
    logic            busy_o;
    logic            lookup_req_i = 1'b0;
    logic [SigW-1:0] lookup_sig_i = '0;
    logic            lookup_valid_o;
    logic [1:0]      lookup_rrpv_o;
    logic            hit_valid_i = 1'b0;
    logic [SigW-1:0] hit_sig_i = '0;
    logic            evict_valid_i = 1'b0;
    logic [SigW-1:0] evict_sig_i = '0;
    logic            evict_reused_i = 1'b0;
    logic [31:0]     stat_lookup_o;
    logic [31:0]     stat_distant_o;

    always #5 clk_i = ~clk_i;

    wt_dcache_shct_predictor #(
        .SigWidth (SigW),
        .CntWidth (CntW)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .flush_i        (flush_i),
        .busy_o         (busy_o),
        .lookup_req_i   (lookup_req_i),
        .lookup_sig_i   (lookup_sig_i),
        .lookup_valid_o (lookup_valid_o),
        .lookup_rrpv_o  (lookup_rrpv_o),
        .hit_valid_i    (hit_valid_i),
        .hit_sig_i      (hit_sig_i),
        .evict_valid_i  (evict_valid_i),
        .evict_sig_i    (evict_sig_i),
        .evict_reused_i (evict_reused_i),
        .stat_lookup_o  (stat_lookup_o),
        .stat_distant_o (stat_distant_o)
    );

    int checks = 0;
    int passed = 0;
    int model [Depth];   // counter value per signature once the clear has finished
    int clr_left = 0;    // busy cycles still to come, including the current one
    int exp_q [$];       // expected RRPVs of outstanding lookups
    int lk_cnt = 0;
    int dist_cnt = 0;
    int mon_exp;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int rrpv_of(input int c);
        if (c == CntMax) return 0;
        if (c == 0) return 3;
        return 2;
    endfunction

    // One clock cycle of stimulus; called just after a rising edge
    task automatic cycle(input bit req, input int ls, input bit hv, input int hs,
                         input bit ev, input int es, input bit er, input bit fl);
        bit busy_now;
        bit hq;
        bit eq;
        int e;
        busy_now = (clr_left > 0);
        check("busy", busy_o, busy_now);
        lookup_req_i   = req;
        lookup_sig_i   = ls[SigW-1:0];
        hit_valid_i    = hv;
        hit_sig_i      = hs[SigW-1:0];
        evict_valid_i  = ev;
        evict_sig_i    = es[SigW-1:0];
        evict_reused_i = er;
        flush_i        = fl;
        if (fl) begin
            lk_cnt   = 0;
            dist_cnt = 0;
        end
        if (req) begin
            e = busy_now ? 2 : rrpv_of(model[ls]);
            exp_q.push_back(e);
            lk_cnt++;
            if (e == 3) dist_cnt++;
        end
        if (!busy_now) begin
            hq = hv;
            eq = ev && !er;
            if (!(hq && eq && hs == es)) begin
                if (hq && model[hs] < CntMax) model[hs]++;
                if (eq && model[es] > 0) model[es]--;
            end
        end
        @(posedge clk_i);
        #1;
        if (fl) begin
            clr_left = Depth;
        end else if (clr_left > 0) begin
            clr_left--;
            if (clr_left == 0) begin
                for (int i = 0; i < Depth; i++) model[i] = CntMax;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic lookup(input int s);
        cycle(1, s, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic hit(input int s);
        cycle(0, 0, 1, s, 0, 0, 0, 0);
    endtask

    task automatic evict(input int s, input bit r);
        cycle(0, 0, 0, 0, 1, s, r, 0);
    endtask

    task automatic check_stats();
`ifdef WT_DCACHE_SHCT_STATS_EN
        check("stat_lookup", stat_lookup_o, lk_cnt);
        check("stat_distant", stat_distant_o, dist_cnt);
`else
        check("stat_lookup_tied", stat_lookup_o, 0);
        check("stat_distant_tied", stat_distant_o, 0);
`endif
    endtask

    // Monitor: every valid lookup response must match the oldest expectation
    always @(negedge clk_i) begin
        if (rst_ni && lookup_valid_o) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", 1, 0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("rrpv", lookup_rrpv_o, mon_exp);
            end
        end
    end

    initial begin
        for (int i = 0; i < Depth; i++) model[i] = CntMax;
        #12;
        check("rst_busy", busy_o, 1);
        check("rst_valid", lookup_valid_o, 0);
        check("rst_rrpv", lookup_rrpv_o, 0);
        check("rst_stat_lookup", stat_lookup_o, 0);
        check("rst_stat_distant", stat_distant_o, 0);
        @(posedge clk_i);
        #1;
        rst_ni   = 1'b1;
        clr_left = Depth;

        // Initial walk: 16 busy cycles, then everything predicts near
        idle(Depth);
        lookup(5);

        // Decrement to distant, then saturation at 0
        evict(7, 0);
        evict(7, 0);
        evict(7, 0);
        lookup(7);
        evict(7, 0);
        lookup(7);

        // Increment recovery and saturation at max
        hit(7);
        lookup(7);
        hit(7);
        hit(7);
        lookup(7);
        hit(7);
        lookup(7);

        // Same-index collision nets to zero
        evict(3, 0);
        cycle(0, 0, 1, 3, 1, 3, 0, 0);
        lookup(3);

        // Lookup sees the pre-update value
        cycle(1, 9, 0, 0, 1, 9, 0, 0);
        lookup(9);

        // Different-index collision: both apply; reused evict is ignored
        cycle(0, 0, 1, 3, 1, 9, 0, 0);
        lookup(3);
        lookup(9);
        evict(3, 1);
        lookup(3);
        idle(2);
        check_stats();

        // Flush from READY, then again mid-walk
        cycle(0, 0, 0, 0, 0, 0, 0, 1);
        idle(9);
        cycle(0, 0, 0, 0, 0, 0, 0, 1);
        check_stats();
        evict(5, 0);
        lookup(5);
        while (clr_left > 0) idle(1);
        lookup(5);
        idle(2);
        check_stats();

        // Randomised traffic against the model
        for (int n = 0; n < 400; n++) begin
            cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, Depth - 1)),
                  1'($urandom_range(0, 1)), int'($urandom_range(0, Depth - 1)),
                  1'($urandom_range(0, 1)), int'($urandom_range(0, Depth - 1)),
                  1'($urandom_range(0, 3) == 0), $urandom_range(0, 79) == 0);
        end
        idle(3);
        while (clr_left > 0) idle(1);
        idle(2);
        check_stats();
        check("drain", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
